sign_narrow_stream: RTL and testbench

// - Inverse of the N->M sign extender: narrows signed M-bit words to N bits on a valid/ready stream.
// - Detects words that do not fit in N signed bits, flags each one and counts them.
// - Two-stage register pipeline at full throughput (1 word/cycle). Sits between a wide datapath
//   (ALU/accumulator) and a narrow sink (immediate/packed field, DAC, narrow bus).

---
 rtl/sign_narrow_stream.sv | 90 +++++++++
 tb/tb_sign_narrow_stream.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sign_narrow_stream.sv
// Two-stage valid/ready pipeline that narrows signed M-bit words to N bits and flags/counts misfits.
// Build option: define SIGN_NARROW_SAT_EN to saturate misfit words; otherwise they wrap.
module sign_narrow_stream #(
  parameter int N     = 12,
  parameter int M     = 32,
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [M-1:0]     i_data,
  input  logic             i_valid,
  output logic             o_ready,
  output logic [N-1:0]     o_data,
  output logic             o_ovf,
  output logic             o_valid,
  input  logic             i_ready,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_ovf_cnt,
  output logic             o_ovf_sticky
);

  localparam int HW = M - N + 1;

  logic           s1_valid;
  logic [M-1:0]   s1_data;
  logic           s2_adv;
  logic           s1_adv;
  logic [HW-1:0]  s1_high;
  logic           s1_fits;
  logic [N-1:0]   s1_narrow;

  assign s2_adv  = !o_valid || i_ready;
  assign s1_adv  = !s1_valid || s2_adv;
  assign o_ready = s1_adv && !i_rst;

  // A word fits when every bit from the MSB down to the new sign bit agrees.
  assign s1_high = s1_data[M-1:N-1];
  assign s1_fits = (s1_high == '0) || (s1_high == '1);

`ifdef SIGN_NARROW_SAT_EN
  always_comb begin
    s1_narrow = s1_data[N-1:0];
    if (!s1_fits) begin
      s1_narrow = s1_data[M-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
    end
  end
`else
  always_comb begin
    s1_narrow = s1_data[N-1:0];
  end
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      o_valid  <= 1'b0;
      o_data   <= '0;
      o_ovf    <= 1'b0;
    end else begin
      if (s2_adv) begin
        o_valid <= s1_valid;
        if (s1_valid) begin
          o_data <= s1_narrow;
          o_ovf  <= !s1_fits;
        end
      end
      if (s1_adv) begin
        s1_valid <= i_valid;
        if (i_valid) begin
          s1_data <= i_data;
        end
      end
    end
  end

  // Clear wins over a same-cycle overflow delivery.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      o_ovf_cnt    <= '0;
      o_ovf_sticky <= 1'b0;
    end else if (o_valid && i_ready && o_ovf) begin
      o_ovf_sticky <= 1'b1;
      if (o_ovf_cnt != {CNT_W{1'b1}}) begin
        o_ovf_cnt <= o_ovf_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_sign_narrow_stream.sv
// Randomised and directed bench for sign_narrow_stream (N=12, M=32) against a queue-based model.
// Expectations follow SIGN_NARROW_SAT_EN when the bench is built with it defined.
module tb_sign_narrow_stream;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] din = '0;
  logic        vin = 1'b0;
  logic        rdy = 1'b0;
  logic        clr = 1'b0;

  logic        o_ready, o_valid, o_ovf, o_sticky;
  logic [11:0] o_data;
  logic [7:0]  o_cnt;
  logic        o4_ready, o4_valid, o4_ovf, o4_sticky;
  logic [11:0] o4_data;
  logic [3:0]  o4_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int n_out    = 0;

  sign_narrow_stream #(.N(12), .M(32), .CNT_W(8)) dut (
    .i_clk(clk), .i_rst(rst), .i_data(din), .i_valid(vin), .o_ready(o_ready),
    .o_data(o_data), .o_ovf(o_ovf), .o_valid(o_valid), .i_ready(rdy), .i_clr(clr),
    .o_ovf_cnt(o_cnt), .o_ovf_sticky(o_sticky)
  );

  sign_narrow_stream #(.N(12), .M(32), .CNT_W(4)) dut4 (
    .i_clk(clk), .i_rst(rst), .i_data(din), .i_valid(vin), .o_ready(o4_ready),
    .o_data(o4_data), .o_ovf(o4_ovf), .o_valid(o4_valid), .i_ready(rdy), .i_clr(clr),
    .o_ovf_cnt(o4_cnt), .o_ovf_sticky(o4_sticky)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference narrowing from the signed value: returns {ovf, data}.
  function automatic logic [12:0] modelNarrow(input logic [31:0] w);
    longint v;
    v = longint'($signed(w));
    if (v >= -2048 && v <= 2047) return {1'b0, w[11:0]};
`ifdef SIGN_NARROW_SAT_EN
    return {1'b1, (v < 0) ? 12'h800 : 12'h7FF};
`else
    return {1'b1, w[11:0]};
`endif
  endfunction

  function automatic logic [31:0] sext12(input logic [11:0] x);
    return {{20{x[11]}}, x};
  endfunction

  logic [12:0] exp_q[$];
  int          m_cnt8 = 0;
  int          m_cnt4 = 0;
  logic        m_sticky = 1'b0;
  logic        prev_stall = 1'b0;
  logic [11:0] prev_data;
  logic        prev_ovf;

  // Compare outputs against the model, then advance the model to what the next edge will do.
  always @(negedge clk) begin
    logic [12:0] e;
    logic        exp_rdy;
    exp_rdy = !rst && (exp_q.size() < 2 || rdy);
    checkOutput("o_ready", o_ready, exp_rdy);
    checkOutput("o_ready_cnt4", o4_ready, exp_rdy);
    checkOutput("ovf_cnt", o_cnt, m_cnt8);
    checkOutput("ovf_cnt4", o4_cnt, m_cnt4);
    checkOutput("ovf_sticky", o_sticky, m_sticky);
    checkOutput("ovf_sticky4", o4_sticky, m_sticky);
    if (exp_q.size() == 0) checkOutput("empty_valid", o_valid, 0);
    if (exp_q.size() == 2) checkOutput("full_valid", o_valid, 1);
    if (prev_stall) begin
      checkOutput("stall_valid", o_valid, 1);
      checkOutput("stall_data", o_data, prev_data);
      checkOutput("stall_ovf", o_ovf, prev_ovf);
    end
    if (rst) begin
      exp_q.delete();
      m_cnt8   = 0;
      m_cnt4   = 0;
      m_sticky = 1'b0;
    end else begin
      if (o_valid && rdy) begin
        if (exp_q.size() == 0) begin
          checkOutput("spurious_out", o_valid, 0);
        end else begin
          e = exp_q.pop_front();
          n_out++;
          checkOutput("out_data", o_data, e[11:0]);
          checkOutput("out_ovf", o_ovf, e[12]);
          checkOutput("out_data4", o4_data, e[11:0]);
          if (e[12]) begin
            m_sticky = 1'b1;
            if (m_cnt8 < 255) m_cnt8++;
            if (m_cnt4 < 15) m_cnt4++;
          end
        end
      end
      if (clr) begin
        m_cnt8   = 0;
        m_cnt4   = 0;
        m_sticky = 1'b0;
      end
      if (vin && o_ready) exp_q.push_back(modelNarrow(din));
    end
    prev_stall = o_valid && !rdy && !rst;
    prev_data  = o_data;
    prev_ovf   = o_ovf;
  end

  logic acc;

  task automatic applyStimulus(input logic [31:0] d, input logic v, input logic r,
                               input logic c, input logic rs, output logic accepted);
    @(posedge clk);
    #1;
    din = d; vin = v; rdy = r; clr = c; rst = rs;
    @(negedge clk);
    accepted = v && o_ready && !rs;
  endtask

  task automatic idle(input int n);
    logic a;
    for (int i = 0; i < n; i++) applyStimulus(32'h0, 1'b0, 1'b1, 1'b0, 1'b0, a);
  endtask

  // One isolated word: it is on the output two edges after capture.
  task automatic checkWord(input logic [31:0] w, input logic [11:0] lit, input logic ovf,
                           input string nm);
    logic a;
    applyStimulus(w, 1'b1, 1'b1, 1'b0, 1'b0, a);
    checkOutput({nm, "_accept"}, a, 1);
    applyStimulus(32'h0, 1'b0, 1'b1, 1'b0, 1'b0, a);
    applyStimulus(32'h0, 1'b0, 1'b1, 1'b0, 1'b0, a);
    checkOutput({nm, "_valid"}, o_valid, 1);
    checkOutput({nm, "_data"}, o_data, lit);
    checkOutput({nm, "_ovf"}, o_ovf, ovf);
  endtask

  logic [11:0] lit_pos_ovf, lit_neg_ovf, lit_big;

  initial begin
    int          widx;
    int          out_start;
    logic        saw_low;
    logic [31:0] words[8];
    logic        r;
    logic [11:0] x;
    int          tries;

`ifdef SIGN_NARROW_SAT_EN
    lit_pos_ovf = 12'h7FF; lit_neg_ovf = 12'h800; lit_big = 12'h7FF;
`else
    lit_pos_ovf = 12'h800; lit_neg_ovf = 12'h7FF; lit_big = 12'h678;
`endif

    repeat (2) @(negedge clk);
    checkOutput("rst_valid", o_valid, 0);
    checkOutput("rst_data", o_data, 0);
    checkOutput("rst_ovf", o_ovf, 0);
    checkOutput("rst_cnt", o_cnt, 0);
    checkOutput("rst_sticky", o_sticky, 0);
    checkOutput("rst_ready", o_ready, 0);

    idle(2);
    checkWord(32'h00000000, 12'h000, 1'b0, "edge_zero");
    checkWord(32'h000007FF, 12'h7FF, 1'b0, "edge_max");
    checkWord(32'hFFFFF800, 12'h800, 1'b0, "edge_min");
    checkWord(32'hFFFFFFFF, 12'hFFF, 1'b0, "edge_m1");
    checkWord(32'h00000800, lit_pos_ovf, 1'b1, "ovf_pos");
    checkWord(32'hFFFFF7FF, lit_neg_ovf, 1'b1, "ovf_neg");
    idle(2);
    checkOutput("edge_cnt", o_cnt, 2);
    checkOutput("edge_sticky", o_sticky, 1);

    // Back-to-back stream with the sink stalled for cycles 3..6.
    for (int i = 0; i < 8; i++) words[i] = sext12(12'($urandom));
    widx = 0; saw_low = 1'b0; out_start = n_out;
    for (int cyc = 0; cyc < 30; cyc++) begin
      r = !(cyc >= 3 && cyc <= 6);
      applyStimulus((widx < 8) ? words[widx] : 32'h0, widx < 8, r, 1'b0, 1'b0, acc);
      if (widx < 8 && !acc) saw_low = 1'b1;
      if (acc) widx++;
    end
    checkOutput("stall_all_accepted", widx, 8);
    checkOutput("stall_ready_fell", saw_low, 1);
    checkOutput("stall_out_count", n_out - out_start, 8);

    // Round trip of sign-extended 12-bit values under random backpressure.
    for (int i = 0; i < 1000; i++) begin
      x = 12'($urandom);
      tries = 0;
      do begin
        applyStimulus(sext12(x), 1'b1, $urandom_range(0, 3) != 0, 1'b0, 1'b0, acc);
        tries++;
      end while (!acc && tries < 40);
      if (!acc) begin
        checkOutput("rt_accept_timeout", acc, 1);
        break;
      end
    end
    idle(4);
    checkOutput("rt_cnt", o_cnt, 2);
    checkOutput("rt_sticky", o_sticky, 1);

    // Saturating counter: 20 overflows on the 4-bit instance.
    applyStimulus(32'h0, 1'b0, 1'b1, 1'b1, 1'b0, acc);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(32'h40000000 + 32'($urandom_range(0, 1000)), 1'b1, 1'b1, 1'b0, 1'b0, acc);
    end
    idle(4);
    checkOutput("sat_cnt4", o4_cnt, 15);
    checkOutput("sat_cnt8", o_cnt, 20);

    // Clear coincides with the 21st overflow delivery.
    applyStimulus(32'h80000000, 1'b1, 1'b1, 1'b0, 1'b0, acc);
    applyStimulus(32'h0, 1'b0, 1'b1, 1'b0, 1'b0, acc);
    applyStimulus(32'h0, 1'b0, 1'b1, 1'b1, 1'b0, acc);
    checkOutput("clr_word_valid", o_valid, 1);
    applyStimulus(32'h0, 1'b0, 1'b1, 1'b0, 1'b0, acc);
    checkOutput("clr_cnt4", o4_cnt, 0);
    checkOutput("clr_cnt8", o_cnt, 0);
    checkOutput("clr_sticky", o_sticky, 0);

    // Reset with two words in flight.
    checkWord(32'h12345678, lit_big, 1'b1, "pre_rst");
    applyStimulus(32'h00000123, 1'b1, 1'b0, 1'b0, 1'b0, acc);
    applyStimulus(32'hF0000000, 1'b1, 1'b0, 1'b0, 1'b0, acc);
    applyStimulus(32'h0, 1'b0, 1'b0, 1'b0, 1'b1, acc);
    checkOutput("pre_rst_cnt", o_cnt, 1);
    applyStimulus(32'h0, 1'b0, 1'b1, 1'b0, 1'b0, acc);
    checkOutput("post_rst_valid", o_valid, 0);
    checkOutput("post_rst_cnt", o_cnt, 0);
    checkOutput("post_rst_sticky", o_sticky, 0);
    idle(5);

    // Fully random traffic including clears and rare resets.
    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom_range(0, 1) != 0) ? 32'($urandom) : sext12(12'($urandom)),
                    $urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7,
                    $urandom_range(0, 49) == 0, $urandom_range(0, 299) == 0, acc);
    end
    idle(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
